ext_int_arbiter: RTL and testbench
==================================

# ext_int_arbiter

Collects one-cycle interrupt request pulses from up to N_SRC external interrupt handlers and latches them into a pending register. It selects one eligible source and presents it to the CPU core through a request/acknowledge/done handshake. It sits between the external interrupt handler instances and the core's interrupt entry logic. Only one interrupt is in service at a time; there is no nesting.

## Interface
- N_SRC, 4: number of interrupt sources, 2..16.
- ID_W, $clog2(N_SRC): width of the source index.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- src_pulse  input  N_SRC  one-cycle request pulses, one bit per handler.
- src_mask  input  N_SRC  per-source enable, 1 = enabled.
- gie  input  1  global interrupt enable.
- int_ack  input  1  CPU accepts the presented interrupt; 1-cycle pulse.
- int_done  input  1  CPU finished the ISR (return from interrupt); 1-cycle pulse.
- int_req  output  1  interrupt presented to the CPU.
- int_id  output  ID_W  index of the presented or in-service source.
- in_service  output  1  an ISR is in progress.
- pending  output  N_SRC  pending register, readable by software.

## Operation
- Pending register:
  - Bit i sets when src_pulse[i] & src_mask[i].
  - Bit i clears on acceptance of source i (int_ack in REQ).
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
  - A pulse on a masked source is dropped.
  - A bit already pending stays pending when its source is masked later, but it is not eligible while masked.
- Eligible sources = pending & src_mask.
- Selection without round-robin: the lowest-index eligible source wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if gie and eligible ≠ 0, go to REQ. int_req←1 and int_id←selected index, both registered on that same edge.
  - REQ: int_req and int_id are held stable until int_ack. A change to gie, mask, or pending does not withdraw or change the request. On int_ack: go to SERVICE, int_req←0, in_service←1, clear pending[int_id].
  - SERVICE: int_id is held. On int_done: go to IDLE, in_service←0.
- int_ack outside REQ and int_done outside SERVICE are ignored.
- int_ack and int_done in the same cycle: only the signal matching the current state acts.
- Reset value of every output is 0. FSM resets to IDLE.
- Asserting rst_n low mid-handshake aborts the handshake immediately and discards all pending bits.

## Timing
- src_pulse[i] at edge t: pending[i]=1 after edge t.
- If in IDLE with gie=1: int_req=1 and int_id valid after edge t+1.
- Total latency is 2 cycles from pulse to int_req.
- int_ack sampled at edge a: int_req=0, in_service=1, and pending bit cleared after edge a.
- int_done sampled at edge d: IDLE after edge d. The next int_req can appear after edge d+1 at the earliest.
- Back-to-back throughput is one interrupt per 3 cycles when ack and done arrive immediately.

## Configuration
- Macro EXT_INT_ROUND_ROBIN_EN.
- Defined:
  - Add an ID_W last-grant pointer, reset to N_SRC-1, updated to int_id on each int_ack.
  - The search starts at pointer+1 and wraps modulo N_SRC. The first eligible source in that order wins.
  - Pointer = N_SRC-1 wraps the search start to 0.
- Undefined: fixed priority, index 0 highest. No pointer register exists.

## Test plan
- Single source: pulse src 2 at cycle 5 → pending=0100 at 6, int_req=1 and int_id=2 at 7; ack at 9 → pending=0000, in_service=1 at 10; done at 12 → in_service=0 at 13.
- Simultaneous pulses on sources 1 and 3 in fixed priority: served as id 1 then id 3. Under EXT_INT_ROUND_ROBIN_EN after a prior grant of 1, pulses on 1 and 3 together are served as 3 then 1.
- gie=0 with pending=0010: int_req stays 0. Setting gie=1 gives int_req=1, int_id=1 one cycle later. Dropping gie during REQ leaves int_req held at 1.
- Pulse on src 0 with src_mask[0]=0: pending stays 0000 and int_req stays 0. Masking a pending source leaves the bit set but gives no request until it is unmasked.
- Re-pulse src 2 in the same cycle as int_ack for id 2: pending[2] stays 1, and int_req reasserts for id 2 two cycles after int_done.
- rst_n low during SERVICE with pending=1010: all outputs are 0 immediately; after release, a stray int_done is ignored.

Source files
------------

// File: rtl/ext_int_arbiter_if.sv
// CPU-side interrupt handshake bundle for ext_int_arbiter: request/id/in-service
// from the arbiter, ack/done from the core's interrupt entry logic.
interface ext_int_arbiter_if #(
  parameter int unsigned N_SRC = 4
);
  localparam int unsigned ID_W = $clog2(N_SRC);

  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic            in_service;
  logic            int_ack;
  logic            int_done;

  modport master (
    output int_req,
    output int_id,
    output in_service,
    input  int_ack,
    input  int_done
  );

  modport slave (
    input  int_req,
    input  int_id,
    input  in_service,
    output int_ack,
    output int_done
  );
endinterface

// File: rtl/ext_int_arbiter.sv
// External interrupt arbiter: latches source pulses into a pending register and
// serves one at a time. Define EXT_INT_ROUND_ROBIN_EN for rotating priority.
module ext_int_arbiter #(
  parameter int unsigned N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_pulse,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             gie,
  output logic [N_SRC-1:0] pending,
  ext_int_arbiter_if.master cpu
);
  localparam int unsigned ID_W = $clog2(N_SRC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             int_req_q, int_req_nxt;
  logic [ID_W-1:0]  int_id_q, int_id_nxt;
  logic             in_service_q, in_service_nxt;
  logic [N_SRC-1:0] pending_q, pending_nxt;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic             sel_found;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W-1:0]  search_start;

  assign eligible = pending_q & src_mask;

`ifdef EXT_INT_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;

  // Search begins just after the last granted source, wrapping at N_SRC.
  always_comb begin
    if (rr_ptr == ID_W'(N_SRC - 1)) search_start = '0;
    else                            search_start = rr_ptr + ID_W'(1);
  end
`else
  assign search_start = '0;
`endif

  // First eligible source in search order, starting at search_start.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = (32'(search_start) + k) % N_SRC;
      if (!sel_found && eligible[ID_W'(idx)]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(idx);
      end
    end
  end

  // Next-state and registered-output logic; only the handshake input that
  // matches the current state is acted on.
  always_comb begin
    state_nxt      = state;
    int_req_nxt    = int_req_q;
    int_id_nxt     = int_id_q;
    in_service_nxt = in_service_q;
    clr            = '0;
`ifdef EXT_INT_ROUND_ROBIN_EN
    rr_ptr_nxt     = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (gie && sel_found) begin
          state_nxt   = REQ;
          int_req_nxt = 1'b1;
          int_id_nxt  = sel_id;
        end
      end
      REQ: begin
        if (cpu.int_ack) begin
          state_nxt      = SERVICE;
          int_req_nxt    = 1'b0;
          in_service_nxt = 1'b1;
          clr[int_id_q]  = 1'b1;
`ifdef EXT_INT_ROUND_ROBIN_EN
          rr_ptr_nxt     = int_id_q;
`endif
        end
      end
      SERVICE: begin
        if (cpu.int_done) begin
          state_nxt      = IDLE;
          in_service_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new pulse overrides a same-cycle acceptance clear.
    pending_nxt = (pending_q & ~clr) | (src_pulse & src_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
`ifdef EXT_INT_ROUND_ROBIN_EN
      rr_ptr       <= ID_W'(N_SRC - 1);
`endif
    end else begin
      state        <= state_nxt;
      int_req_q    <= int_req_nxt;
      int_id_q     <= int_id_nxt;
      in_service_q <= in_service_nxt;
      pending_q    <= pending_nxt;
`ifdef EXT_INT_ROUND_ROBIN_EN
      rr_ptr       <= rr_ptr_nxt;
`endif
    end
  end

  assign cpu.int_req    = int_req_q;
  assign cpu.int_id     = int_id_q;
  assign cpu.in_service = in_service_q;
  assign pending        = pending_q;
endmodule

// File: tb/tb_ext_int_arbiter.sv
// Scoreboard bench for ext_int_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_ext_int_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam logic [N-1:0] ALL = 4'b1111;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

`ifdef EXT_INT_ROUND_ROBIN_EN
  localparam int FIRST_ID  = 3;
  localparam int SECOND_ID = 1;
`else
  localparam int FIRST_ID  = 1;
  localparam int SECOND_ID = 3;
`endif

  typedef struct packed {
    logic           req;
    logic           svc;
    logic [IDW-1:0] id;
    logic [N-1:0]   pend;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] src_pulse;
  logic [N-1:0] src_mask;
  logic         gie;
  logic [N-1:0] pending;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: pending set, handshake phase, held id, last grant.
  bit [N-1:0] m_pend;
  int         m_mode;
  int         m_id;
  int         m_last;

  ext_int_arbiter_if #(.N_SRC(N)) bus ();

  ext_int_arbiter #(.N_SRC(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_pulse (src_pulse),
    .src_mask  (src_mask),
    .gie       (gie),
    .pending   (pending),
    .cpu       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_n, got, want);
    end
  endtask

  function automatic void model_reset();
    m_pend = '0;
    m_mode = M_IDLE;
    m_id   = 0;
    m_last = N - 1;
  endfunction

  // Pick the winning pending+enabled source, or -1 if none.
  function automatic int model_pick(input logic [N-1:0] elig);
    int start;
`ifdef EXT_INT_ROUND_ROBIN_EN
    start = (m_last + 1) % N;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (((elig >> ((start + k) % N)) & N'(1)) != '0) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [N-1:0] p, input logic [N-1:0] m,
                                     input logic g, input logic a, input logic d);
    bit [N-1:0] np;
    int w;
    np = m_pend;
    if (m_mode == M_IDLE) begin
      w = model_pick(m_pend & m);
      if (g && w >= 0) begin
        m_mode = M_REQ;
        m_id   = w;
      end
    end else if (m_mode == M_REQ) begin
      if (a) begin
        np     = np & ~(N'(1) << m_id);
        m_mode = M_SVC;
        m_last = m_id;
      end
    end else begin
      if (d) m_mode = M_IDLE;
    end
    m_pend = np | (p & m);
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then land just after the edge.
  task automatic cyc(input logic [N-1:0] p, input logic [N-1:0] m,
                     input logic g, input logic a, input logic d);
    exp_t e;
    @(negedge clk);
    rst_n        = 1'b1;
    src_pulse    = p;
    src_mask     = m;
    gie          = g;
    bus.int_ack  = a;
    bus.int_done = d;
    model_step(p, m, g, a, d);
    e.req  = (m_mode == M_REQ);
    e.svc  = (m_mode == M_SVC);
    e.id   = IDW'(m_id);
    e.pend = m_pend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc('0, ALL, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    exp_t e;
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    src_pulse    = '0;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    model_reset();
    #1;
    chk({tag, "_int_req"},    32'(bus.int_req),    32'd0);
    chk({tag, "_in_service"}, 32'(bus.in_service), 32'd0);
    chk({tag, "_int_id"},     32'(bus.int_id),     32'd0);
    chk({tag, "_pending"},    32'(pending),        32'd0);
    e = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int id, input string tag);
    idle();
    chk({tag, "_req"}, 32'(bus.int_req), 32'd1);
    chk({tag, "_id"},  32'(bus.int_id),  32'(id));
    cyc('0, ALL, 1'b1, 1'b1, 1'b0);
    chk({tag, "_in_service"}, 32'(bus.in_service), 32'd1);
    cyc('0, ALL, 1'b1, 1'b0, 1'b1);
    chk({tag, "_done"}, 32'(bus.in_service), 32'd0);
  endtask

  // Monitor: every edge with a prediction outstanding is checked against it.
  always @(posedge clk) begin
    cyc_n++;
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("mon_int_req",    32'(bus.int_req),    32'(mon_e.req));
      chk("mon_in_service", 32'(bus.in_service), 32'(mon_e.svc));
      chk("mon_pending",    32'(pending),        32'(mon_e.pend));
      if (mon_e.req || mon_e.svc) chk("mon_int_id", 32'(bus.int_id), 32'(mon_e.id));
    end
  end

  initial begin
    rst_n        = 1'b0;
    src_pulse    = '0;
    src_mask     = '0;
    gie          = 1'b0;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_int_req",    32'(bus.int_req),    32'd0);
    chk("reset_in_service", 32'(bus.in_service), 32'd0);
    chk("reset_int_id",     32'(bus.int_id),     32'd0);
    chk("reset_pending",    32'(pending),        32'd0);
    idle();

    // Single source timing: pending next edge, request one edge later.
    cyc(4'b0100, ALL, 1'b1, 1'b0, 1'b0);
    chk("single_pending", 32'(pending),     32'h4);
    chk("single_no_req",  32'(bus.int_req), 32'd0);
    idle();
    chk("single_req", 32'(bus.int_req), 32'd1);
    chk("single_id",  32'(bus.int_id),  32'd2);
    idle();
    cyc('0, ALL, 1'b1, 1'b1, 1'b0);
    chk("single_ack_pending", 32'(pending),        32'h0);
    chk("single_ack_svc",     32'(bus.in_service), 32'd1);
    chk("single_ack_req",     32'(bus.int_req),    32'd0);
    idle();
    cyc('0, ALL, 1'b1, 1'b0, 1'b1);
    chk("single_done_svc", 32'(bus.in_service), 32'd0);
    idle();

    // Prior grant of 1, then 1 and 3 together.
    cyc(4'b0010, ALL, 1'b1, 1'b0, 1'b0);
    serve(1, "prior");
    cyc(4'b1010, ALL, 1'b1, 1'b0, 1'b0);
    serve(FIRST_ID, "pair_first");
    serve(SECOND_ID, "pair_second");

    // Global enable gating and request hold.
    cyc(4'b0010, ALL, 1'b0, 1'b0, 1'b0);
    cyc('0, ALL, 1'b0, 1'b0, 1'b0);
    cyc('0, ALL, 1'b0, 1'b0, 1'b0);
    chk("gie_off_pending", 32'(pending),     32'h2);
    chk("gie_off_req",     32'(bus.int_req), 32'd0);
    cyc('0, ALL, 1'b1, 1'b0, 1'b0);
    chk("gie_on_req", 32'(bus.int_req), 32'd1);
    chk("gie_on_id",  32'(bus.int_id),  32'd1);
    cyc('0, ALL, 1'b0, 1'b0, 1'b0);
    cyc('0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("gie_drop_hold_req", 32'(bus.int_req), 32'd1);
    chk("gie_drop_hold_id",  32'(bus.int_id),  32'd1);
    cyc('0, ALL, 1'b0, 1'b1, 1'b0);
    cyc('0, ALL, 1'b1, 1'b0, 1'b1);

    // Masked pulse dropped; masked pending bit kept but not served.
    cyc(4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0);
    idle();
    chk("mask_drop_pending", 32'(pending),     32'h0);
    chk("mask_drop_req",     32'(bus.int_req), 32'd0);
    cyc(4'b0100, ALL, 1'b0, 1'b0, 1'b0);
    cyc('0, 4'b1011, 1'b1, 1'b0, 1'b0);
    cyc('0, 4'b1011, 1'b1, 1'b0, 1'b0);
    chk("mask_keep_pending", 32'(pending),     32'h4);
    chk("mask_keep_req",     32'(bus.int_req), 32'd0);
    serve(2, "unmask");

    // Re-pulse on the acked source keeps it pending and re-requests after done.
    cyc(4'b0100, ALL, 1'b1, 1'b0, 1'b0);
    idle();
    cyc(4'b0100, ALL, 1'b1, 1'b1, 1'b0);
    chk("repulse_pending", 32'(pending),        32'h4);
    chk("repulse_svc",     32'(bus.in_service), 32'd1);
    cyc('0, ALL, 1'b1, 1'b0, 1'b1);
    chk("repulse_done_req", 32'(bus.int_req), 32'd0);
    idle();
    chk("repulse_rereq", 32'(bus.int_req), 32'd1);
    chk("repulse_id",    32'(bus.int_id),  32'd2);
    cyc('0, ALL, 1'b1, 1'b1, 1'b0);
    cyc('0, ALL, 1'b1, 1'b0, 1'b1);

    // Reset in SERVICE with other sources pending, then a stray done.
    cyc(4'b0100, ALL, 1'b1, 1'b0, 1'b0);
    idle();
    cyc('0, ALL, 1'b1, 1'b1, 1'b0);
    cyc(4'b1010, ALL, 1'b1, 1'b0, 1'b0);
    chk("prerst_pending", 32'(pending),        32'ha);
    chk("prerst_svc",     32'(bus.in_service), 32'd1);
    async_reset("midrst");
    cyc('0, ALL, 1'b1, 1'b0, 1'b0);
    cyc('0, ALL, 1'b1, 1'b0, 1'b1);
    chk("stray_done_svc", 32'(bus.in_service), 32'd0);
    chk("stray_done_req", 32'(bus.int_req),    32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] p;
      logic [N-1:0] m;
      logic g;
      logic a;
      logic d;
      p = N'($urandom) & N'($urandom) & N'($urandom);
      m = ($urandom_range(0, 5) == 0) ? N'($urandom) : ALL;
      g = ($urandom_range(0, 7) != 0);
      a = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      if (i == 300) async_reset("rand_rst");
      cyc(p, m, g, a, d);
    end
    repeat (3) idle();
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
